// File: rtl/dds_lut_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_lut_ctrl
// Brief    : Load sequencer and two-channel round-robin read arbiter for the
//            single-port DDS sine LUT SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module dds_lut_ctrl #(
    parameter int AW    = 14,
    parameter int DW    = 16,
    parameter int DEPTH = 16384
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          load_done,
    input  logic          req0,
    input  logic [AW-1:0] idx0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] idx1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam logic [1:0]    c_st_idle   = 2'd0;
    localparam logic [1:0]    c_st_load   = 2'd1;
    localparam logic [1:0]    c_st_run    = 2'd2;
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_addr_one  = AW'(1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_ld_addr;
    logic          r_load_done;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          r_last;      // channel granted most recently (1 = channel 1)

    logic          w_wr;
    logic          w_run_ok;
    logic          w_gnt0;
    logic          w_gnt1;

    // A load_start in RUN steals the cycle, so no read is granted alongside it.
    always_comb begin
        w_wr     = (r_state == c_st_load) && ld_valid;
        w_run_ok = (r_state == c_st_run) && !load_start;
        w_gnt0   = w_run_ok && req0 && (!req1 || r_last);
        w_gnt1   = w_run_ok && req1 && (!req0 || !r_last);
    end

    always_comb begin
        ld_ready = (r_state == c_st_load);
        gnt0     = w_gnt0;
        gnt1     = w_gnt1;
        sram_cen = !(w_wr || w_gnt0 || w_gnt1);
        sram_wen = !w_wr;
        sram_a   = '0;
        sram_d   = '0;
        if (w_wr) begin
            sram_a = r_ld_addr;
            sram_d = ld_data;
        end else if (w_gnt0) begin
            sram_a = idx0;
        end else if (w_gnt1) begin
            sram_a = idx1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_ld_addr   <= '0;
            r_load_done <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (load_start) begin
                        r_state   <= c_st_load;
                        r_ld_addr <= '0;
                    end
                end
                c_st_load: begin
                    if (w_wr) begin
                        r_ld_addr <= r_ld_addr + c_addr_one;
                        if (r_ld_addr == c_last_addr) begin
                            r_state     <= c_st_run;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                c_st_run: begin
                    if (load_start) begin
                        r_state     <= c_st_load;
                        r_load_done <= 1'b0;
                        r_ld_addr   <= '0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign load_done = r_load_done;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rvalid0 ? sram_q : '0;
    assign rdata1    = r_rvalid1 ? sram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dds_lut_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_lut_ctrl
// Brief    : Randomized scoreboard bench for dds_lut_ctrl with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_lut_ctrl;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_ready, load_done;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [13:0] idx0 = '0, idx1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        sram_cen, sram_wen;
    logic [13:0] sram_a;
    logic [15:0] sram_d;
    logic [15:0] sram_q = '0;

    dds_lut_ctrl #(.AW(14), .DW(16), .DEPTH(16384)) dut (
        .sys_clk(sys_clk), .reset(reset), .load_start(load_start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .load_done(load_done),
        .req0(req0), .idx0(idx0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .idx1(idx1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural single-port SRAM: read data appears the cycle after the address edge.
    logic [15:0] sram_mem [16384];
    always @(posedge sys_clk) begin
        if (!sram_cen) begin
            if (!sram_wen) sram_mem[sram_a] <= sram_d;
            else           sram_q <= sram_mem[sram_a];
        end
    end

    typedef struct packed {
        logic        wr;
        logic        g0;
        logic        g1;
        logic        rv0;
        logic        rv1;
        logic        ldr;
        logic        done;
        logic        zero;
        logic [13:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: what has been loaded and who is owed the next tie.
    logic [15:0] ref_mem [16384];
    bit          m_loading, m_running, m_done, m_pg0, m_pg1, m_last;
    logic [13:0] m_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ld_ready", 32'(ld_ready), 32'(e.ldr));
            chk("load_done", 32'(load_done), 32'(e.done));
            chk("gnt0", 32'(gnt0), 32'(e.g0));
            chk("gnt1", 32'(gnt1), 32'(e.g1));
            chk("rvalid0", 32'(rvalid0), 32'(e.rv0));
            chk("rvalid1", 32'(rvalid1), 32'(e.rv1));
            chk("sram_cen", 32'(sram_cen), 32'(!(e.wr || e.g0 || e.g1)));
            if (e.wr || e.g0 || e.g1) begin
                chk("sram_wen", 32'(sram_wen), 32'(!e.wr));
                chk("sram_a", 32'(sram_a), 32'(e.a));
            end
            if (e.wr) chk("sram_d", 32'(sram_d), 32'(e.d));
            if (e.zero) begin
                chk("sram_a_idle", 32'(sram_a), 32'd0);
                chk("sram_d_idle", 32'(sram_d), 32'd0);
                chk("sram_wen_idle", 32'(sram_wen), 32'd1);
            end
        end
        if (rvalid0) begin
            if (q0.size() == 0) chk("rvalid0_unexpected", 32'(rvalid0), 32'd0);
            else                chk("rdata0", 32'(rdata0), 32'(q0.pop_front()));
        end else begin
            chk("rdata0_idle", 32'(rdata0), 32'd0);
        end
        if (rvalid1) begin
            if (q1.size() == 0) chk("rvalid1_unexpected", 32'(rvalid1), 32'd0);
            else                chk("rdata1", 32'(rdata1), 32'(q1.pop_front()));
        end else begin
            chk("rdata1_idle", 32'(rdata1), 32'd0);
        end
    end

    task automatic rst_cycle();
        exp_t e;
        @(posedge sys_clk); #1;
        reset = 1'b1;
        load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        req0 = 1'b0; req1 = 1'b0; idx0 = '0; idx1 = '0;
        q0.delete(); q1.delete();
        m_loading = 0; m_running = 0; m_done = 0; m_pg0 = 0; m_pg1 = 0;
        m_last = 1; m_addr = '0;
        e = '0;
        e.zero = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit ls, input bit lv, input logic [15:0] ld,
                        input bit r0, input logic [13:0] i0,
                        input bit r1, input logic [13:0] i1);
        exp_t e;
        bit   g0, g1;
        @(posedge sys_clk); #1;
        reset = 1'b0;
        load_start = ls; ld_valid = lv; ld_data = ld;
        req0 = r0; idx0 = i0; req1 = r1; idx1 = i1;
        // Round robin: a lone requester wins; on a tie the one not served last wins.
        g0 = m_running && !ls && r0 && (!r1 || m_last);
        g1 = m_running && !ls && r1 && (!r0 || !m_last);
        e      = '0;
        e.ldr  = m_loading;
        e.done = m_done;
        e.rv0  = m_pg0;
        e.rv1  = m_pg1;
        e.zero = !m_loading && !m_running;
        e.wr   = m_loading && lv;
        e.g0   = g0;
        e.g1   = g1;
        e.a    = e.wr ? m_addr : (g0 ? i0 : (g1 ? i1 : 14'h0));
        e.d    = e.wr ? ld : 16'h0;
        exp_q.push_back(e);
        if (g0) q0.push_back(ref_mem[i0]);
        if (g1) q1.push_back(ref_mem[i1]);
        if (m_loading && lv) begin
            ref_mem[m_addr] = ld;
            if (m_addr == 14'h3FFF) begin
                m_loading = 0; m_running = 1; m_done = 1;
            end
            m_addr = m_addr + 14'h1;
        end else if (!m_loading && ls) begin
            m_loading = 1; m_running = 0; m_done = 0; m_addr = '0;
        end
        m_pg0 = g0;
        m_pg1 = g1;
        if (g0)      m_last = 0;
        else if (g1) m_last = 1;
    endtask

    task automatic load_full_dense();
        for (int k = 0; k < 16384; k++)
            step(0, 1, 16'(m_addr) ^ 16'h5A5A, 1'($urandom), 14'($urandom), 1'($urandom), 14'($urandom));
    endtask

    task automatic load_gapped();
        int cyc = 0;
        while (m_loading && cyc < 40000) begin
            step(0, ($urandom_range(0, 9) >= 3), 16'($urandom),
                 1'($urandom), 14'($urandom), 1'($urandom), 14'($urandom));
            cyc++;
        end
        if (m_loading) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_timeout actual=%0d required=<40000 cycles", cyc);
        end
    endtask

    task automatic random_reads(input int n);
        for (int k = 0; k < n; k++)
            step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b0, 0, 16'($urandom),
                 1'($urandom), 14'($urandom), 1'($urandom), 14'($urandom));
    endtask

    initial begin
        rst_cycle();
        rst_cycle();
        // Dense load with data = address ^ 5A5A.
        step(1, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        load_full_dense();
        step(0, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        // Single channel-0 read of address 0x0010.
        step(0, 0, 16'h0, 1, 14'h0010, 0, 14'h0);
        step(0, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        // Both channels held high: grants alternate.
        for (int k = 0; k < 6; k++) step(0, 0, 16'h0, 1, 14'h0001, 1, 14'h0002);
        step(0, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        random_reads(300);
        // Channel-1 grant followed by load_start with req0 held.
        step(0, 0, 16'h0, 0, 14'h0, 1, 14'h0123);
        step(1, 0, 16'h0, 1, 14'h0456, 0, 14'h0);
        load_gapped();
        random_reads(200);
        // Reset mid-load at address 0x1234, then reload from address 0.
        step(1, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        while (m_loading && m_addr != 14'h1234)
            step(0, 1, 16'($urandom), 0, 14'h0, 0, 14'h0);
        rst_cycle();
        step(0, 1, 16'hFFFF, 1, 14'h0, 1, 14'h0);
        step(1, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        load_full_dense();
        random_reads(200);
        step(0, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        step(0, 0, 16'h0, 0, 14'h0, 0, 14'h0);
        @(negedge sys_clk); #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
